// File: rtl/rnd_pkg.sv
// Shared definitions for the random-word pool.
//   RND_W       : width of raw and conditioned words
//   ROT_AMT     : left-rotate applied to the history before mixing
//   rnd_state_e : warm-up / run FSM states
//   fifo_req_t  : one cycle's write/read request into the word buffer
//   rnd_mix     : conditioning function, rnd ^ rotl(hist, ROT_AMT)
package rnd_pkg;

  localparam int RND_W   = 32;
  localparam int ROT_AMT = 5;

  typedef logic [RND_W-1:0] rnd_word_t;

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } rnd_state_e;

  typedef struct packed {
    logic      push;
    logic      pop;
    rnd_word_t data;
  } fifo_req_t;

  // Pure XOR/rotate: no carries, so every output bit depends on exactly
  // one raw bit and one history bit.
  function automatic rnd_word_t rnd_mix(input rnd_word_t rnd, input rnd_word_t hist);
    rnd_word_t rot;
    rot = (hist << ROT_AMT) | (hist >> (RND_W - ROT_AMT));
    return rnd ^ rot;
  endfunction

endpackage

// File: rtl/rnd_fifo.sv
// Generic first-word-fall-through FIFO.
//   clk, rst  : clock, asynchronous active-high reset
//   push_i    : write wdata_i this cycle (ignored when full without a pop)
//   pop_i     : consume the head this cycle (ignored when empty)
//   wdata_i   : write data
//   rdata_o   : head entry, valid whenever valid_o=1, no read latency
//   count_o   : exact fill level 0..DEPTH
//   valid_o   : FIFO non-empty
// DEPTH must be a power of two so the pointers wrap for free.
module rnd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdata_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL  = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [AW-1:0] P_ONE = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  // A push at full is legal only when the head leaves in the same cycle.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != FULL) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + P_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + P_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + C_ONE;
      2'b01:   count_d = count_q - C_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign valid_o = (count_q != '0);

endmodule

// File: rtl/rnd_pool.sv
// Buffered random-word source fed by a free-running 32-bit LFSR.
//   I_clk, I_reset : clock, asynchronous active-high reset
//   I_rnd          : raw LFSR word, new every cycle
//   I_pop          : consumer takes O_data (effective only when O_valid=1)
//   O_valid        : at least one conditioned word buffered
//   O_data         : head word (first-word-fall-through)
//   O_count        : fill level 0..DEPTH
//   O_underflow    : sticky, set by a pop request while empty
// After reset WARMUP raw words are folded into the history without being
// stored, so the first words handed out already depend on several LFSR
// outputs. In RUN every stored word also becomes the new history; when the
// buffer is full and nobody pops, raw words are dropped and history holds.
module rnd_pool
  import rnd_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WARMUP = 8
) (
  input  logic                   I_clk,
  input  logic                   I_reset,
  input  logic [RND_W-1:0]       I_rnd,
  input  logic                   I_pop,
  output logic                   O_valid,
  output logic [RND_W-1:0]       O_data,
  output logic [$clog2(DEPTH):0] O_count,
  output logic                   O_underflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]  FULL      = CW'(DEPTH);
  localparam logic [7:0]     WARM_INIT = 8'(WARMUP);
  // With no warm-up there is nothing to absorb; start producing at once.
  localparam rnd_state_e     RST_STATE = (WARMUP == 0) ? RUN : WARM;

  rnd_state_e    state_q, state_d;
  logic [7:0]    warm_q, warm_d;
  rnd_word_t     hist_q, hist_d;
  logic          uf_q, uf_d;

  rnd_word_t     mix;
  logic          absorb;
  fifo_req_t     req;
  logic          fifo_valid;
  logic [CW-1:0] fifo_count;
  rnd_word_t     fifo_data;

  assign mix = rnd_mix(I_rnd, hist_q);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q <= RST_STATE;
      warm_q  <= WARM_INIT;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      WARM: begin
        warm_d = warm_q - 8'd1;
        // <=1 rather than ==1 so a corrupted zero count cannot stall here.
        if (warm_q <= 8'd1) state_d = RUN;
      end
      RUN:     state_d = RUN;
      default: state_d = RST_STATE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    absorb   = 1'b0;
    req      = '0;
    req.data = mix;
    req.pop  = I_pop && fifo_valid;
    case (state_q)
      WARM: absorb = 1'b1;
      RUN: begin
        req.push = (fifo_count != FULL) || req.pop;
        absorb   = req.push;
      end
      default: absorb = 1'b0;
    endcase
  end

  // ---------------- history and underflow ----------------
  always_comb begin
    hist_d = absorb ? mix : hist_q;
    uf_d   = uf_q || (I_pop && !fifo_valid);
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      hist_q <= '0;
      uf_q   <= 1'b0;
    end else begin
      hist_q <= hist_d;
      uf_q   <= uf_d;
    end
  end

  // ---------------- word buffer ----------------
  rnd_fifo #(
    .DEPTH (DEPTH),
    .W     (RND_W)
  ) u_fifo (
    .clk     (I_clk),
    .rst     (I_reset),
    .push_i  (req.push),
    .pop_i   (req.pop),
    .wdata_i (req.data),
    .rdata_o (fifo_data),
    .count_o (fifo_count),
    .valid_o (fifo_valid)
  );

  assign O_valid     = fifo_valid;
  assign O_data      = fifo_data;
  assign O_count     = fifo_count;
  assign O_underflow = uf_q;

endmodule
